raster_scan: RTL and testbench

RASTER_SCAN -- requirements
Module: raster_scan

---
 rtl/raster_scan_if.sv | 24 ++
 rtl/raster_scan.sv | 137 +++++++++++++
 tb/tb_raster_scan.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/raster_scan_if.sv
// Pixel-side bundle between the raster scanner and the shading logic / video sink.
// The scanner (master) publishes coordinates and timed video; the shader side
// (slave) supplies the pixel-rate enable and the colour for the published coordinate.
interface raster_scan_if;
  logic        pix_en;
  logic [12:0] x_given;
  logic [12:0] y_given;
  logic [19:0] color_given;
  logic [19:0] color_out;
  logic        de;
  logic        hsync_n;
  logic        vsync_n;
  logic        frame_start;

  modport master (
    input  pix_en, color_given,
    output x_given, y_given, color_out, de, hsync_n, vsync_n, frame_start
  );

  modport slave (
    output pix_en, color_given,
    input  x_given, y_given, color_out, de, hsync_n, vsync_n, frame_start
  );
endinterface

// File: rtl/raster_scan.sv
// Raster scan timing generator: horizontal/vertical counters, region FSMs that
// follow the counters, and one registered stage that samples the shader colour
// and emits blanking, data-enable, syncs and a frame-start pulse, all aligned.
module raster_scan #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic          clk,
  input  logic          rst,
  raster_scan_if.master bus
);

  // Region boundaries and wrap points as 13-bit counter values.
  localparam logic [12:0] H_MAX        = 13'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [12:0] H_FP_START   = 13'(H_ACTIVE);
  localparam logic [12:0] H_SYNC_START = 13'(H_ACTIVE + H_FP);
  localparam logic [12:0] H_BP_START   = 13'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [12:0] V_MAX        = 13'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [12:0] V_FP_START   = 13'(V_ACTIVE);
  localparam logic [12:0] V_SYNC_START = 13'(V_ACTIVE + V_FP);
  localparam logic [12:0] V_BP_START   = 13'(V_ACTIVE + V_FP + V_SYNC);

  // Sync-region states carry a _PULSE suffix so they do not clash with the
  // sync-width parameters of the same name.
  typedef enum logic [1:0] {H_ACT, H_FRONT, H_SYNC_PULSE, H_BACK} h_state_t;
  typedef enum logic [1:0] {V_ACT, V_FRONT, V_SYNC_PULSE, V_BACK} v_state_t;

  logic [12:0] h_cnt_reg, h_cnt_next;
  logic [12:0] v_cnt_reg, v_cnt_next;
  logic        h_wrap;
  h_state_t    h_state_reg, h_state_next;
  v_state_t    v_state_reg, v_state_next;

  logic [19:0] color_reg, color_next;
  logic        de_reg, de_next;
  logic        hsync_n_reg, hsync_n_next;
  logic        vsync_n_reg, vsync_n_next;
  logic        frame_start_reg, frame_start_next;

  // Counter advance: h steps every enabled cycle, v steps on the h wrap.
  always_comb begin
    h_cnt_next = h_cnt_reg;
    v_cnt_next = v_cnt_reg;
    h_wrap     = (h_cnt_reg == H_MAX);
    if (bus.pix_en) begin
      if (h_wrap) begin
        h_cnt_next = 13'd0;
        v_cnt_next = (v_cnt_reg == V_MAX) ? 13'd0 : v_cnt_reg + 13'd1;
      end else begin
        h_cnt_next = h_cnt_reg + 13'd1;
      end
    end
  end

  // Counter and FSM state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt_reg   <= 13'd0;
      v_cnt_reg   <= 13'd0;
      h_state_reg <= H_ACT;
      v_state_reg <= V_ACT;
    end else begin
      h_cnt_reg   <= h_cnt_next;
      v_cnt_reg   <= v_cnt_next;
      h_state_reg <= h_state_next;
      v_state_reg <= v_state_next;
    end
  end

  // Region next-state: a region is entered when the counter reaches its first
  // value; vertical regions only move on the end of a line.
  always_comb begin
    h_state_next = h_state_reg;
    v_state_next = v_state_reg;
    if (bus.pix_en) begin
      if (h_cnt_next == 13'd0)              h_state_next = H_ACT;
      else if (h_cnt_next == H_FP_START)    h_state_next = H_FRONT;
      else if (h_cnt_next == H_SYNC_START)  h_state_next = H_SYNC_PULSE;
      else if (h_cnt_next == H_BP_START)    h_state_next = H_BACK;
      if (h_wrap) begin
        if (v_cnt_next == 13'd0)              v_state_next = V_ACT;
        else if (v_cnt_next == V_FP_START)    v_state_next = V_FRONT;
        else if (v_cnt_next == V_SYNC_START)  v_state_next = V_SYNC_PULSE;
        else if (v_cnt_next == V_BP_START)    v_state_next = V_BACK;
      end
    end
  end

  // Output decode: values for the video stage, held when the enable is low;
  // frame_start is a strict one-cycle pulse and never holds.
  always_comb begin
    color_next       = color_reg;
    de_next          = de_reg;
    hsync_n_next     = hsync_n_reg;
    vsync_n_next     = vsync_n_reg;
    frame_start_next = 1'b0;
    if (bus.pix_en) begin
      de_next          = (h_state_reg == H_ACT) && (v_state_reg == V_ACT);
      color_next       = de_next ? bus.color_given : 20'h0;
      hsync_n_next     = (h_state_reg != H_SYNC_PULSE);
      vsync_n_next     = (v_state_reg != V_SYNC_PULSE);
      frame_start_next = (h_cnt_reg == 13'd0) && (v_cnt_reg == 13'd0);
    end
  end

  // Video output stage, one enabled cycle behind the coordinates.
  always_ff @(posedge clk) begin
    if (rst) begin
      color_reg       <= 20'h0;
      de_reg          <= 1'b0;
      hsync_n_reg     <= 1'b1;
      vsync_n_reg     <= 1'b1;
      frame_start_reg <= 1'b0;
    end else begin
      color_reg       <= color_next;
      de_reg          <= de_next;
      hsync_n_reg     <= hsync_n_next;
      vsync_n_reg     <= vsync_n_next;
      frame_start_reg <= frame_start_next;
    end
  end

  assign bus.x_given     = h_cnt_reg;
  assign bus.y_given     = v_cnt_reg;
  assign bus.color_out   = color_reg;
  assign bus.de          = de_reg;
  assign bus.hsync_n     = hsync_n_reg;
  assign bus.vsync_n     = vsync_n_reg;
  assign bus.frame_start = frame_start_reg;

endmodule

// File: tb/tb_raster_scan.sv
// Bench for raster_scan: a default-timing instance and a tiny-timing instance
// run side by side against a model that tracks the linear pixel index of the
// frame and derives coordinates and regions from it arithmetically.
module tb_raster_scan;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   cyc;

  raster_scan_if ifa ();
  raster_scan_if ifb ();

  raster_scan u_def (.clk(clk), .rst(rst), .bus(ifa));
  raster_scan #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) u_small (.clk(clk), .rst(rst), .bus(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Timing parameters per instance (0 = default, 1 = small).
  int ha [2] = '{640, 4};
  int hf [2] = '{16, 1};
  int hs [2] = '{96, 1};
  int va [2] = '{480, 2};
  int vf [2] = '{10, 1};
  int vs [2] = '{2, 1};
  int htot [2] = '{800, 7};
  int vtot [2] = '{525, 5};

  // Observed outputs gathered per instance.
  logic [12:0] ox [2];
  logic [12:0] oy [2];
  logic [19:0] ocol [2];
  logic        ode [2];
  logic        ohs [2];
  logic        ovs [2];
  logic        ofs [2];
  assign ox[0] = ifa.x_given;     assign ox[1] = ifb.x_given;
  assign oy[0] = ifa.y_given;     assign oy[1] = ifb.y_given;
  assign ocol[0] = ifa.color_out; assign ocol[1] = ifb.color_out;
  assign ode[0] = ifa.de;         assign ode[1] = ifb.de;
  assign ohs[0] = ifa.hsync_n;    assign ohs[1] = ifb.hsync_n;
  assign ovs[0] = ifa.vsync_n;    assign ovs[1] = ifb.vsync_n;
  assign ofs[0] = ifa.frame_start; assign ofs[1] = ifb.frame_start;

  // Model state: pixel index currently being scanned and expected outputs.
  int          m_p [2];
  logic [19:0] m_col [2];
  logic        m_de [2];
  logic        m_hs [2];
  logic        m_vs [2];
  logic        m_fs [2];

  // One clock: drive inputs, advance the model across the edge, settle.
  task automatic tick(input logic r, input logic e0, input logic e1, input logic fixc);
    logic [19:0] c [2];
    logic        e [2];
    int x, y;
    logic act;
    e[0] = e0;
    e[1] = e1;
    for (int d = 0; d < 2; d++) c[d] = fixc ? 20'hABCDE : 20'($urandom);
    rst = r;
    ifa.pix_en = e0;
    ifb.pix_en = e1;
    ifa.color_given = c[0];
    ifb.color_given = c[1];
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (r) begin
        m_p[d] = 0; m_col[d] = 20'h0; m_de[d] = 1'b0;
        m_hs[d] = 1'b1; m_vs[d] = 1'b1; m_fs[d] = 1'b0;
      end else if (e[d]) begin
        x = m_p[d] % htot[d];
        y = m_p[d] / htot[d];
        act = (x < ha[d]) && (y < va[d]);
        m_de[d]  = act;
        m_col[d] = act ? c[d] : 20'h0;
        m_hs[d]  = !((x >= ha[d] + hf[d]) && (x < ha[d] + hf[d] + hs[d]));
        m_vs[d]  = !((y >= va[d] + vf[d]) && (y < va[d] + vf[d] + vs[d]));
        m_fs[d]  = (m_p[d] == 0);
        m_p[d]   = (m_p[d] + 1) % (htot[d] * vtot[d]);
      end else begin
        m_fs[d] = 1'b0;
      end
    end
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'($urandom), 1'($urandom), 1'b0);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (ox[d] !== 13'd0 || oy[d] !== 13'd0 || ocol[d] !== 20'h0 || ode[d] !== 1'b0 ||
            ohs[d] !== 1'b1 || ovs[d] !== 1'b1 || ofs[d] !== 1'b0) begin
          failures++;
          $display("FAIL reset dut%0d got x=%0d y=%0d col=%h de=%b hs=%b vs=%b fs=%b exp 0 0 0 0 1 1 0",
                   d, ox[d], oy[d], ocol[d], ode[d], ohs[d], ovs[d], ofs[d]);
        end
      end
    end
    $display("test_reset done checks=%0d failures=%0d", checks, failures);
  endtask

  // Three default lines with a constant shader colour; also counts per-line totals.
  task automatic test_line_timing();
    int de_cnt, hs_low, col_cnt;
    de_cnt = 0; hs_low = 0; col_cnt = 0;
    for (int i = 0; i < 2400; i++) begin
      tick(1'b0, 1'b1, 1'b1, 1'b1);
      if (ode[0] === 1'b1) de_cnt++;
      if (ohs[0] === 1'b0) hs_low++;
      if (ocol[0] === 20'hABCDE) col_cnt++;
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (ox[d] !== 13'(m_p[d] % htot[d]) || oy[d] !== 13'(m_p[d] / htot[d]) ||
            ocol[d] !== m_col[d] || ode[d] !== m_de[d] || ohs[d] !== m_hs[d] ||
            ovs[d] !== m_vs[d] || ofs[d] !== m_fs[d]) begin
          failures++;
          $display("FAIL line_timing dut%0d cyc=%0d got x=%0d y=%0d col=%h de=%b hs=%b vs=%b fs=%b exp x=%0d y=%0d col=%h de=%b hs=%b vs=%b fs=%b",
                   d, cyc, ox[d], oy[d], ocol[d], ode[d], ohs[d], ovs[d], ofs[d],
                   m_p[d] % htot[d], m_p[d] / htot[d], m_col[d], m_de[d], m_hs[d], m_vs[d], m_fs[d]);
        end
      end
    end
    checks++;
    if (de_cnt != 1920 || col_cnt != 1920 || hs_low != 288) begin
      failures++;
      $display("FAIL line_totals got de=%0d col=%0d hs_low=%0d exp 1920 1920 288", de_cnt, col_cnt, hs_low);
    end
    $display("test_line_timing done checks=%0d failures=%0d", checks, failures);
  endtask

  // Small instance: full frames with pix_en held or toggled; frame period and extremes.
  task automatic test_small_frames(input bit toggle);
    int last_fs, period, max_x, max_y, pulses;
    last_fs = -1; period = -1; max_x = 0; max_y = 0; pulses = 0;
    for (int i = 0; i < 240; i++) begin
      logic en;
      en = toggle ? ((i % 2) == 0) : 1'b1;
      tick(1'b0, en, en, 1'b0);
      if (ofs[1] === 1'b1) begin
        if (last_fs >= 0) period = cyc - last_fs;
        last_fs = cyc;
        pulses++;
      end
      if (int'(ox[1]) > max_x) max_x = int'(ox[1]);
      if (int'(oy[1]) > max_y) max_y = int'(oy[1]);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (ox[d] !== 13'(m_p[d] % htot[d]) || oy[d] !== 13'(m_p[d] / htot[d]) ||
            ocol[d] !== m_col[d] || ode[d] !== m_de[d] || ohs[d] !== m_hs[d] ||
            ovs[d] !== m_vs[d] || ofs[d] !== m_fs[d]) begin
          failures++;
          $display("FAIL small_frames dut%0d cyc=%0d got x=%0d y=%0d col=%h de=%b hs=%b vs=%b fs=%b exp x=%0d y=%0d col=%h de=%b hs=%b vs=%b fs=%b",
                   d, cyc, ox[d], oy[d], ocol[d], ode[d], ohs[d], ovs[d], ofs[d],
                   m_p[d] % htot[d], m_p[d] / htot[d], m_col[d], m_de[d], m_hs[d], m_vs[d], m_fs[d]);
        end
      end
    end
    checks++;
    if (period != (toggle ? 70 : 35) || max_x != 6 || max_y != 4 || pulses < 2) begin
      failures++;
      $display("FAIL small_period toggle=%0d got period=%0d max_x=%0d max_y=%0d pulses=%0d exp period=%0d max_x=6 max_y=4",
               toggle, period, max_x, max_y, pulses, toggle ? 70 : 35);
    end
    $display("test_small_frames toggle=%0d done checks=%0d failures=%0d", toggle, checks, failures);
  endtask

  // Independent random enables on both instances with random colours.
  task automatic test_random_enable();
    for (int i = 0; i < 3000; i++) begin
      tick(1'b0, 1'($urandom_range(0, 3) != 0), 1'($urandom), 1'b0);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (ox[d] !== 13'(m_p[d] % htot[d]) || oy[d] !== 13'(m_p[d] / htot[d]) ||
            ocol[d] !== m_col[d] || ode[d] !== m_de[d] || ohs[d] !== m_hs[d] ||
            ovs[d] !== m_vs[d] || ofs[d] !== m_fs[d]) begin
          failures++;
          $display("FAIL random_enable dut%0d cyc=%0d got x=%0d y=%0d col=%h de=%b hs=%b vs=%b fs=%b exp x=%0d y=%0d col=%h de=%b hs=%b vs=%b fs=%b",
                   d, cyc, ox[d], oy[d], ocol[d], ode[d], ohs[d], ovs[d], ofs[d],
                   m_p[d] % htot[d], m_p[d] / htot[d], m_col[d], m_de[d], m_hs[d], m_vs[d], m_fs[d]);
        end
      end
    end
    $display("test_random_enable done checks=%0d failures=%0d", checks, failures);
  endtask

  // Reset mid-line at x=300 on the default instance, then restart scanning.
  task automatic test_reset_mid();
    int n;
    n = 0;
    while (ox[0] !== 13'd300 && n < 2000) begin
      tick(1'b0, 1'b1, 1'b1, 1'b0);
      n++;
    end
    checks++;
    if (ox[0] !== 13'd300) begin
      failures++;
      $display("FAIL reset_mid_reach got x=%0d exp 300 within 2000 cycles", ox[0]);
    end
    tick(1'b1, 1'b0, 1'b1, 1'b0);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (ox[d] !== 13'd0 || oy[d] !== 13'd0 || ocol[d] !== 20'h0 || ode[d] !== 1'b0 ||
          ohs[d] !== 1'b1 || ovs[d] !== 1'b1 || ofs[d] !== 1'b0) begin
        failures++;
        $display("FAIL reset_mid dut%0d got x=%0d y=%0d col=%h de=%b hs=%b vs=%b fs=%b exp 0 0 0 0 1 1 0",
                 d, ox[d], oy[d], ocol[d], ode[d], ohs[d], ovs[d], ofs[d]);
      end
    end
    for (int i = 0; i < 1000; i++) begin
      tick(1'b0, (i != 1), 1'b1, 1'b0);
      if (i == 0) begin
        checks++;
        if (ofs[0] !== 1'b1 || ox[0] !== 13'd1 || ode[0] !== 1'b1) begin
          failures++;
          $display("FAIL restart_first got fs=%b x=%0d de=%b exp fs=1 x=1 de=1", ofs[0], ox[0], ode[0]);
        end
      end
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (ox[d] !== 13'(m_p[d] % htot[d]) || oy[d] !== 13'(m_p[d] / htot[d]) ||
            ocol[d] !== m_col[d] || ode[d] !== m_de[d] || ohs[d] !== m_hs[d] ||
            ovs[d] !== m_vs[d] || ofs[d] !== m_fs[d]) begin
          failures++;
          $display("FAIL reset_restart dut%0d cyc=%0d got x=%0d y=%0d col=%h de=%b hs=%b vs=%b fs=%b exp x=%0d y=%0d col=%h de=%b hs=%b vs=%b fs=%b",
                   d, cyc, ox[d], oy[d], ocol[d], ode[d], ohs[d], ovs[d], ofs[d],
                   m_p[d] % htot[d], m_p[d] / htot[d], m_col[d], m_de[d], m_hs[d], m_vs[d], m_fs[d]);
        end
      end
    end
    $display("test_reset_mid done checks=%0d failures=%0d", checks, failures);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    cyc = 0;
    rst = 1'b1;
    ifa.pix_en = 1'b0;
    ifb.pix_en = 1'b0;
    ifa.color_given = 20'h0;
    ifb.color_given = 20'h0;
    for (int d = 0; d < 2; d++) begin
      m_p[d] = 0; m_col[d] = 20'h0; m_de[d] = 1'b0;
      m_hs[d] = 1'b1; m_vs[d] = 1'b1; m_fs[d] = 1'b0;
    end
    test_reset();
    test_line_timing();
    test_small_frames(1'b0);
    test_small_frames(1'b1);
    test_random_enable();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
